mpu_ctx_ctrl: RTL and testbench

// Context sequencer for the MPU. Tracks nested interrupt preemption and keeps a

---
 rtl/mpu_ctx_ctrl_if.sv | 50 +++++
 rtl/mpu_ctx_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mpu_ctx_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_ctx_ctrl_if.sv
// ---------------------------------------------------------------------------
// mpu_ctx_ctrl_if
// Bundles the context-sequencer signals shared between the core side and the
// sequencer.
//   master : core/handler side. Drives priority, task id, stack pointer, the
//            MPU fault strobe with its access info, and the fault ack.
//            Receives the ep/id context, stack status and the fault record.
//   slave  : the sequencer (mpu_ctx_ctrl).
// Parameters: Depth (frame-stack entries), SpWidth (sp/address width),
//             IdWidth (task id width).
// ---------------------------------------------------------------------------
interface mpu_ctx_ctrl_if #(
  parameter int Depth   = 8,
  parameter int SpWidth = 16,
  parameter int IdWidth = 3
) ();
  localparam int DepthW = $clog2(Depth) + 1;

  logic [7:0]         interrupt_prio;
  logic [IdWidth-1:0] task_id;
  logic [SpWidth-1:0] sp;
  logic               mem_fault_in;
  logic [SpWidth-1:0] addr;
  logic [6:0]         op;
  logic               fault_ack;

  logic [SpWidth-1:0] ep;
  logic [IdWidth-1:0] id;
  logic               busy;
  logic [DepthW-1:0]  depth;
  logic               overflow;
  logic               underflow;
  logic               fault_valid;
  logic [SpWidth-1:0] fault_addr;
  logic [IdWidth-1:0] fault_id;
  logic               fault_store;
  logic               fault_overrun;

  modport master (
    output interrupt_prio, task_id, sp, mem_fault_in, addr, op, fault_ack,
    input  ep, id, busy, depth, overflow, underflow,
           fault_valid, fault_addr, fault_id, fault_store, fault_overrun
  );

  modport slave (
    input  interrupt_prio, task_id, sp, mem_fault_in, addr, op, fault_ack,
    output ep, id, busy, depth, overflow, underflow,
           fault_valid, fault_addr, fault_id, fault_store, fault_overrun
  );
endinterface

// File: rtl/mpu_ctx_ctrl.sv
// ---------------------------------------------------------------------------
// mpu_ctx_ctrl
// Context sequencer for the MPU. Follows nested interrupt preemption by
// comparing the incoming running priority against the tracked one and keeps
// a frame stack of {entry sp, task id, prio}. The active frame drives the
// MPU's ep/id. MPU faults on loads/stores are captured into a held record
// until the handler acknowledges.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : mpu_ctx_ctrl_if.slave
//            in : interrupt_prio, task_id, sp, mem_fault_in, addr, op,
//                 fault_ack
//            out: ep, id, busy (pop pending), depth, overflow, underflow
//                 (both sticky), fault_valid, fault_addr, fault_id,
//                 fault_store, fault_overrun (sticky)
// ---------------------------------------------------------------------------
module mpu_ctx_ctrl #(
  parameter int Depth   = 8,
  parameter int SpWidth = 16,
  parameter int IdWidth = 3
) (
  input  logic          clk,
  input  logic          reset,
  mpu_ctx_ctrl_if.slave bus
);

  localparam int AW = $clog2(Depth);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(Depth);
  localparam logic [6:0]    OP_LOAD    = 7'b0000011;
  localparam logic [6:0]    OP_STORE   = 7'b0100011;

  // Saturating depth arithmetic: the counter never wraps past 0 or Depth.
  function automatic logic [DW-1:0] depth_inc(input logic [DW-1:0] d);
    return (d == DEPTH_FULL) ? d : d + 1'b1;
  endfunction

  function automatic logic [DW-1:0] depth_dec(input logic [DW-1:0] d);
    return (d == '0) ? d : d - 1'b1;
  endfunction

  // ------------------------------------------------------------------------
  // Context tracking
  // ------------------------------------------------------------------------
  logic [7:0]         cur_prio_q, cur_prio_d;
  logic [SpWidth-1:0] ep_q, ep_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  // Frame storage is pure data: no reset, only depth tells what is valid.
  logic [SpWidth-1:0] stack_ep_q   [Depth];
  logic [IdWidth-1:0] stack_id_q   [Depth];
  logic [7:0]         stack_prio_q [Depth];

  logic          push, pop, stack_wr;
  logic [AW-1:0] wr_idx, rd_idx;

  always_comb begin
    push        = bus.interrupt_prio > cur_prio_q;
    pop         = bus.interrupt_prio < cur_prio_q;
    wr_idx      = depth_q[AW-1:0];
    rd_idx      = AW'(depth_q - 1'b1);
    stack_wr    = 1'b0;
    cur_prio_d  = cur_prio_q;
    ep_d        = ep_q;
    id_d        = id_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push) begin
      // A full stack drops the outgoing frame, but the new level still
      // becomes active so the MPU tracks the running context.
      if (depth_q != DEPTH_FULL) begin
        stack_wr = 1'b1;
        depth_d  = depth_inc(depth_q);
      end else begin
        overflow_d = 1'b1;
      end
      ep_d       = bus.sp;
      id_d       = bus.task_id;
      cur_prio_d = bus.interrupt_prio;
    end else if (pop) begin
      // One frame per cycle; a deeper return keeps pop asserted and a
      // restored prio below the incoming one turns into a push next cycle.
      if (depth_q != '0) begin
        ep_d       = stack_ep_q[rd_idx];
        id_d       = stack_id_q[rd_idx];
        cur_prio_d = stack_prio_q[rd_idx];
        depth_d    = depth_dec(depth_q);
      end else begin
        underflow_d = 1'b1;
        ep_d        = '0;
        id_d        = bus.task_id;
        cur_prio_d  = bus.interrupt_prio;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_prio_q  <= '0;
      ep_q        <= '0;
      id_q        <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cur_prio_q  <= cur_prio_d;
      ep_q        <= ep_d;
      id_q        <= id_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stack_wr) begin
      stack_ep_q[wr_idx]   <= ep_q;
      stack_id_q[wr_idx]   <= id_q;
      stack_prio_q[wr_idx] <= cur_prio_q;
    end
  end

  // ------------------------------------------------------------------------
  // Fault capture
  // ------------------------------------------------------------------------
  typedef enum logic {
    FLT_IDLE = 1'b0,
    FLT_HOLD = 1'b1
  } flt_state_e;

  flt_state_e         flt_state_q;
  logic               fault_valid_q;
  logic [SpWidth-1:0] fault_addr_q;
  logic [IdWidth-1:0] fault_id_q;
  logic               fault_store_q;
  logic               fault_overrun_q;
  logic               flt_hit;
  logic               flt_is_store;

  // Only loads and stores produce a record; other opcodes are ignored.
  assign flt_is_store = (bus.op == OP_STORE);
  assign flt_hit      = bus.mem_fault_in && ((bus.op == OP_LOAD) || flt_is_store);

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_state_q     <= FLT_IDLE;
      fault_valid_q   <= 1'b0;
      fault_addr_q    <= '0;
      fault_id_q      <= '0;
      fault_store_q   <= 1'b0;
      fault_overrun_q <= 1'b0;
    end else begin
      case (flt_state_q)
        FLT_IDLE: begin
          if (flt_hit) begin
            flt_state_q   <= FLT_HOLD;
            fault_valid_q <= 1'b1;
            fault_addr_q  <= bus.addr;
            fault_id_q    <= id_q;
            fault_store_q <= flt_is_store;
          end
        end
        FLT_HOLD: begin
          if (bus.fault_ack) begin
            // The ack frees the slot in the same cycle, so a coincident
            // fault is captured rather than counted as an overrun.
            if (flt_hit) begin
              fault_addr_q  <= bus.addr;
              fault_id_q    <= id_q;
              fault_store_q <= flt_is_store;
            end else begin
              flt_state_q   <= FLT_IDLE;
              fault_valid_q <= 1'b0;
            end
          end else if (flt_hit) begin
            fault_overrun_q <= 1'b1;
          end
        end
        default: begin
          flt_state_q   <= FLT_IDLE;
          fault_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ep            = ep_q;
  assign bus.id            = id_q;
  assign bus.busy          = pop;
  assign bus.depth         = depth_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
  assign bus.fault_valid   = fault_valid_q;
  assign bus.fault_addr    = fault_addr_q;
  assign bus.fault_id      = fault_id_q;
  assign bus.fault_store   = fault_store_q;
  assign bus.fault_overrun = fault_overrun_q;

endmodule

// File: tb/tb_mpu_ctx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mpu_ctx_ctrl
// Scoreboard bench for mpu_ctx_ctrl. Each driven cycle pushes the outputs
// expected after the next clock edge; the checker pops and compares them at
// the following falling edge.
// ---------------------------------------------------------------------------
module tb_mpu_ctx_ctrl;
  localparam int Depth   = 8;
  localparam int SpWidth = 16;
  localparam int IdWidth = 3;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mpu_ctx_ctrl_if #(.Depth(Depth), .SpWidth(SpWidth), .IdWidth(IdWidth)) bus ();

  mpu_ctx_ctrl #(.Depth(Depth), .SpWidth(SpWidth), .IdWidth(IdWidth)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] ep;
    logic [2:0]  id;
    logic [3:0]  depth;
    logic        busy;
    logic        ovf;
    logic        unf;
    logic        fv;
    logic        rec;   // record fields are meaningful (held or after reset)
    logic [15:0] fa;
    logic [2:0]  fid;
    logic        fst;
    logic        fovr;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_m();
    m.ep = '0; m.id = '0; m.depth = '0; m.busy = 1'b0;
    m.ovf = 1'b0; m.unf = 1'b0; m.fv = 1'b0; m.rec = 1'b1;
    m.fa = '0; m.fid = '0; m.fst = 1'b0; m.fovr = 1'b0;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e = m;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".ep"},    32'(bus.ep),            32'(e.ep));
      check({e.tag, ".id"},    32'(bus.id),            32'(e.id));
      check({e.tag, ".depth"}, 32'(bus.depth),         32'(e.depth));
      check({e.tag, ".busy"},  32'(bus.busy),          32'(e.busy));
      check({e.tag, ".ovf"},   32'(bus.overflow),      32'(e.ovf));
      check({e.tag, ".unf"},   32'(bus.underflow),     32'(e.unf));
      check({e.tag, ".fv"},    32'(bus.fault_valid),   32'(e.fv));
      check({e.tag, ".fovr"},  32'(bus.fault_overrun), 32'(e.fovr));
      if (e.rec) begin
        check({e.tag, ".faddr"}, 32'(bus.fault_addr),  32'(e.fa));
        check({e.tag, ".fid"},   32'(bus.fault_id),    32'(e.fid));
        check({e.tag, ".fst"},   32'(bus.fault_store), 32'(e.fst));
      end
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic [15:0] s, input logic [2:0] t);
    bus.interrupt_prio = p;
    bus.sp             = s;
    bus.task_id        = t;
  endtask

  task automatic fault(input logic f, input logic [6:0] o, input logic [15:0] a, input logic ack);
    bus.mem_fault_in = f;
    bus.op           = o;
    bus.addr         = a;
    bus.fault_ack    = ack;
  endtask

  function automatic logic [15:0] lvl_sp(input int i);
    return 16'h1000 - 16'(i * 16);
  endfunction

  initial begin
    // 1: reset state
    reset = 1'b1;
    drive(8'd0, 16'h1000, 3'd0);
    fault(1'b0, 7'd0, 16'h0, 1'b0);
    clear_m();
    push_exp("t1_rst");  tick();
    reset = 1'b0;
    push_exp("t1_idle"); tick();

    // 2: two nested levels then full return
    drive(8'd3, 16'h0F00, 3'd2);
    m.ep = 16'h0F00; m.id = 3'd2; m.depth = 4'd1;
    push_exp("t2_push3"); tick();
    drive(8'd5, 16'h0E80, 3'd4);
    m.ep = 16'h0E80; m.id = 3'd4; m.depth = 4'd2;
    push_exp("t2_push5"); tick();
    drive(8'd0, 16'h1000, 3'd0);
    #1 check("t2_busy_pre", 32'(bus.busy), 32'd1);
    m.ep = 16'h0F00; m.id = 3'd2; m.depth = 4'd1; m.busy = 1'b1;
    push_exp("t2_pop1"); tick();
    m.ep = 16'h0000; m.id = 3'd0; m.depth = 4'd0; m.busy = 1'b0;
    push_exp("t2_pop2"); tick();

    // new level entered during a return: pop then push
    drive(8'd3, 16'h0C00, 3'd1);
    m.ep = 16'h0C00; m.id = 3'd1; m.depth = 4'd1;
    push_exp("tp_push3"); tick();
    drive(8'd6, 16'h0B00, 3'd6);
    m.ep = 16'h0B00; m.id = 3'd6; m.depth = 4'd2;
    push_exp("tp_push6"); tick();
    drive(8'd4, 16'h0A00, 3'd5);
    m.ep = 16'h0C00; m.id = 3'd1; m.depth = 4'd1;
    push_exp("tp_pop"); tick();
    m.ep = 16'h0A00; m.id = 3'd5; m.depth = 4'd2;
    push_exp("tp_repush"); tick();
    drive(8'd0, 16'h1000, 3'd0);
    m.ep = 16'h0C00; m.id = 3'd1; m.depth = 4'd1; m.busy = 1'b1;
    push_exp("tp_ret1"); tick();
    m.ep = 16'h0000; m.id = 3'd0; m.depth = 4'd0; m.busy = 1'b0;
    push_exp("tp_ret2"); tick();

    // 3: nine increasing levels overflow an 8-deep stack
    for (int i = 1; i <= 9; i++) begin
      drive(8'(i), lvl_sp(i), 3'(i));
      m.ep = lvl_sp(i); m.id = 3'(i);
      if (i <= Depth) m.depth = 4'(i);
      else            m.ovf   = 1'b1;
      push_exp($sformatf("t3_push%0d", i)); tick();
    end
    // return to thread mode: the dropped frame (level 8) is skipped
    drive(8'd0, 16'h1000, 3'd0);
    for (int k = 1; k <= Depth; k++) begin
      int j;
      j = Depth - k;
      m.ep    = (j == 0) ? 16'h0000 : lvl_sp(j);
      m.id    = 3'(j);
      m.depth = 4'(j);
      m.busy  = (j != 0);
      push_exp($sformatf("t3_pop%0d", k)); tick();
    end

    // 4: load fault, overrun, ack
    drive(8'd1, 16'h0800, 3'd1);
    m.ep = 16'h0800; m.id = 3'd1; m.depth = 4'd1;
    push_exp("t4_ctx"); tick();
    fault(1'b1, OP_LOAD, 16'h2004, 1'b0);
    m.fv = 1'b1; m.rec = 1'b1; m.fa = 16'h2004; m.fid = 3'd1; m.fst = 1'b0;
    push_exp("t4_cap"); tick();
    fault(1'b0, 7'd0, 16'h0, 1'b0);
    push_exp("t4_hold"); tick();
    fault(1'b1, OP_STORE, 16'h2100, 1'b0);
    m.fovr = 1'b1;
    push_exp("t4_ovr"); tick();
    fault(1'b0, 7'd0, 16'h0, 1'b1);
    m.fv = 1'b0; m.rec = 1'b0;
    push_exp("t4_ack"); tick();
    fault(1'b1, OP_ALU, 16'h2200, 1'b1);
    push_exp("t4_alu_ack_idle"); tick();
    fault(1'b0, 7'd0, 16'h0, 1'b0);

    // 5: ack coincident with a new store fault
    reset = 1'b1;
    drive(8'd0, 16'h1000, 3'd0);
    clear_m();
    push_exp("t5_rst"); tick();
    reset = 1'b0;
    fault(1'b1, OP_LOAD, 16'h2200, 1'b0);
    m.fv = 1'b1; m.fa = 16'h2200; m.fid = 3'd0; m.fst = 1'b0;
    push_exp("t5_cap"); tick();
    fault(1'b1, OP_STORE, 16'h3000, 1'b1);
    m.fa = 16'h3000; m.fst = 1'b1;
    push_exp("t5_recap"); tick();
    fault(1'b0, 7'd0, 16'h0, 1'b0);
    push_exp("t5_hold"); tick();

    // 6: reset in the middle of a pop sequence with a record held
    drive(8'd2, 16'h0700, 3'd3);
    m.ep = 16'h0700; m.id = 3'd3; m.depth = 4'd1;
    push_exp("t6_push2"); tick();
    drive(8'd4, 16'h0600, 3'd5);
    m.ep = 16'h0600; m.id = 3'd5; m.depth = 4'd2;
    push_exp("t6_push4"); tick();
    drive(8'd0, 16'h1000, 3'd0);
    m.ep = 16'h0700; m.id = 3'd3; m.depth = 4'd1; m.busy = 1'b1;
    push_exp("t6_pop1"); tick();
    reset = 1'b1;
    clear_m();
    push_exp("t6_rst"); tick();
    reset = 1'b0;
    push_exp("t6_after"); tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
